dma_read_fetch: RTL and testbench

DMA_READ_FETCH -- requirements
Module: dma_read_fetch

---
 rtl/dma_read_fetch.sv | 156 +++++++++++++++
 tb/tb_dma_read_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_read_fetch.sv
// Purpose: issue one DMA read command per transfer and convert the 512-bit read beats into 256-bit fetch words.
// Latency: start to command is 3 cycles (two start registers plus IDLE); a data beat to its first fetch word is 1 cycle.
// Backpressure: fetch_almost_full stops emission, and DMA ready drops while the holding register still has unsent data.
//
// Ports:
//   hbm_clk, hbm_areset               - clock and asynchronous active-high reset
//   m_axis_dma_read_cmd_*             - read command (valid/ready, address[63:0], length[31:0])
//   s_axis_dma_read_data_*            - read data stream (data[511:0]; keep and last are not used)
//   start, addr_x, data_length        - transfer request; the request is taken from IDLE on the delayed start
//   fetch_data, fetch_valid           - 256-bit words toward the HBM side, with no ready signal
//   fetch_almost_full                 - downstream programmable-full flag
//   busy, done                        - busy outside IDLE; done is a one-cycle completion pulse
module dma_read_fetch (
  input  logic         hbm_clk,
  input  logic         hbm_areset,

  output logic         m_axis_dma_read_cmd_valid,
  input  logic         m_axis_dma_read_cmd_ready,
  output logic [63:0]  m_axis_dma_read_cmd_address,
  output logic [31:0]  m_axis_dma_read_cmd_length,

  input  logic [511:0] s_axis_dma_read_data_data,
  input  logic [63:0]  s_axis_dma_read_data_keep,
  input  logic         s_axis_dma_read_data_valid,
  output logic         s_axis_dma_read_data_ready,
  input  logic         s_axis_dma_read_data_last,

  input  logic         start,
  input  logic [63:0]  addr_x,
  input  logic [31:0]  data_length,

  output logic [255:0] fetch_data,
  output logic         fetch_valid,
  input  logic         fetch_almost_full,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] ST_IDLE     = 4'b0001;
  localparam logic [3:0] ST_SEND_CMD = 4'b0010;
  localparam logic [3:0] ST_RECV     = 4'b0100;
  localparam logic [3:0] ST_DONE     = 4'b1000;

  logic [3:0]   state;
  logic         start_q0;
  logic         start_d1;
  logic [63:0]  addr_q;
  logic [31:0]  len_q;
  logic [31:0]  cmd_len_q;
  logic [31:0]  bytes_acc;
  logic [31:0]  bytes_emit;
  logic [511:0] hold_dat;
  logic         hold_vld;
  logic         half;

  logic         st_idle;
  logic         st_recv;
  logic         go;
  logic [31:0]  cmd_len_calc;
  logic         emit;
  logic         lower_last;
  logic         final_emit;
  logic         dma_hs;

  // keep and last are not needed: the length fully defines the beat count.
  logic         unused_sigs;
  assign unused_sigs = ^{s_axis_dma_read_data_keep, s_axis_dma_read_data_last};

  assign st_idle = (state == ST_IDLE);
  assign st_recv = (state == ST_RECV);
  assign go      = st_idle & start_d1;

  // The DMA engine moves whole 64-byte beats, so round the request up to one.
  assign cmd_len_calc = (data_length + 32'd63) & ~32'd63;

  assign emit = hold_vld & ~fetch_almost_full;
  // The upper half of the final beat is padding when the length is an odd number of 32-byte words.
  // bytes_emit stays at or below len_q - 32 here, so adding 32 cannot wrap.
  assign lower_last = (bytes_emit + 32'd32) >= len_q;
  assign final_emit = emit & (half | lower_last);

  // A new beat may land in the same cycle that the last half of the previous beat leaves.
  assign s_axis_dma_read_data_ready = st_recv & (bytes_acc < cmd_len_q) & (~hold_vld | final_emit);
  assign dma_hs = s_axis_dma_read_data_ready & s_axis_dma_read_data_valid;

  assign m_axis_dma_read_cmd_valid   = (state == ST_SEND_CMD);
  assign m_axis_dma_read_cmd_address = addr_q;
  assign m_axis_dma_read_cmd_length  = cmd_len_q;
  assign busy = ~st_idle;
  assign done = (state == ST_DONE);

  always_ff @(posedge hbm_clk or posedge hbm_areset) begin
    if (hbm_areset) begin
      state     <= ST_IDLE;
      start_q0  <= 1'b0;
      start_d1  <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      cmd_len_q <= '0;
    end else begin
      start_q0 <= start;
      start_d1 <= start_q0;
      case (state)
        ST_IDLE: begin
          if (start_d1) begin
            addr_q    <= addr_x;
            len_q     <= data_length;
            cmd_len_q <= cmd_len_calc;
            state     <= (data_length == 32'd0) ? ST_DONE : ST_SEND_CMD;
          end
        end
        ST_SEND_CMD: begin
          if (m_axis_dma_read_cmd_ready) state <= ST_RECV;
        end
        ST_RECV: begin
          if ((bytes_emit >= len_q) && !hold_vld) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge hbm_clk or posedge hbm_areset) begin
    if (hbm_areset) begin
      bytes_acc   <= '0;
      bytes_emit  <= '0;
      hold_dat    <= '0;
      hold_vld    <= 1'b0;
      half        <= 1'b0;
      fetch_data  <= '0;
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= emit;
      if (go) begin
        bytes_acc  <= '0;
        bytes_emit <= '0;
      end else begin
        if (emit) begin
          fetch_data <= half ? hold_dat[511:256] : hold_dat[255:0];
          bytes_emit <= bytes_emit + 32'd32;
          if (half | lower_last) hold_vld <= 1'b0;
          else                   half     <= 1'b1;
        end
        // A new beat is loaded after the emission above so that it takes priority.
        if (dma_hs) begin
          hold_dat  <= s_axis_dma_read_data_data;
          hold_vld  <= 1'b1;
          half      <= 1'b0;
          bytes_acc <= bytes_acc + 32'd64;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_read_fetch.sv
// Purpose: randomized self-checking bench for dma_read_fetch against a queue-based transfer model.
// Latency: model expectations are written when a handshake is seen; outputs are sampled on the falling edge.
// Backpressure: the bench drives cmd ready delay, DMA valid gaps and fetch_almost_full stalls.
module tb_dma_read_fetch;

  logic         hbm_clk = 1'b0;
  logic         hbm_areset = 1'b1;
  logic         cmd_valid;
  logic         cmd_ready = 1'b0;
  logic [63:0]  cmd_addr;
  logic [31:0]  cmd_len;
  logic [511:0] s_data = '0;
  logic [63:0]  s_keep = '1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         s_last = 1'b0;
  logic         start = 1'b0;
  logic [63:0]  addr_x = '0;
  logic [31:0]  data_length = '0;
  logic [255:0] fetch_data;
  logic         fetch_valid;
  logic         fetch_almost_full = 1'b0;
  logic         busy;
  logic         done;

  dma_read_fetch dut (
    .hbm_clk                     (hbm_clk),
    .hbm_areset                  (hbm_areset),
    .m_axis_dma_read_cmd_valid   (cmd_valid),
    .m_axis_dma_read_cmd_ready   (cmd_ready),
    .m_axis_dma_read_cmd_address (cmd_addr),
    .m_axis_dma_read_cmd_length  (cmd_len),
    .s_axis_dma_read_data_data   (s_data),
    .s_axis_dma_read_data_keep   (s_keep),
    .s_axis_dma_read_data_valid  (s_valid),
    .s_axis_dma_read_data_ready  (s_ready),
    .s_axis_dma_read_data_last   (s_last),
    .start                       (start),
    .addr_x                      (addr_x),
    .data_length                 (data_length),
    .fetch_data                  (fetch_data),
    .fetch_valid                 (fetch_valid),
    .fetch_almost_full           (fetch_almost_full),
    .busy                        (busy),
    .done                        (done)
  );

  always #5 hbm_clk = ~hbm_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Transfer model state.
  logic [255:0] exp_q[$];
  logic [63:0]  exp_addr;
  logic [31:0]  exp_clen;
  int n_words, words_pushed, words_seen, beats_acc, cmds, done_cnt;
  int first_cyc, last_cyc, done_cyc, busy_cyc, cmdv_cyc;
  int cyc = 0;
  int cmd_delay = 0;
  int dma_mode = 0;
  int af_mode = 0;
  int stall_left = 0;
  bit dma_taken = 1'b0;
  bit af_last = 1'b0;

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial forever begin
    @(posedge hbm_clk);
    cyc++;
  end

  // Monitor and scoreboard.
  initial forever begin
    @(negedge hbm_clk);
    if (!hbm_areset) begin
      if (af_last) chk("af_gate", fetch_valid, 0);
      if (s_valid && s_ready) begin
        beats_acc++;
        dma_taken = 1'b1;
        if (words_pushed < n_words) begin exp_q.push_back(s_data[255:0]);   words_pushed++; end
        if (words_pushed < n_words) begin exp_q.push_back(s_data[511:256]); words_pushed++; end
      end
      if (fetch_valid) begin
        chk("word_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("word", fetch_data, exp_q.pop_front());
        words_seen++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (cmd_valid) begin
        cmdv_cyc++;
        chk("cmd_addr", cmd_addr, exp_addr);
        chk("cmd_len", cmd_len, exp_clen);
        if (cmd_ready) cmds++;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cyc++;
    end
    af_last = fetch_almost_full;
  end

  // DMA data source: valid holds until taken.
  initial forever begin
    @(posedge hbm_clk); #1;
    if (dma_taken || !s_valid) begin
      dma_taken = 1'b0;
      s_data  = rnd512();
      s_valid = (dma_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Command sink with programmable ready delay.
  int cmd_cnt = 0;
  initial forever begin
    @(posedge hbm_clk); #1;
    if (cmd_valid) begin
      cmd_ready = (cmd_cnt >= cmd_delay);
      cmd_cnt++;
    end else begin
      cmd_ready = 1'b0;
      cmd_cnt = 0;
    end
  end

  // Downstream almost-full source.
  initial forever begin
    @(posedge hbm_clk); #1;
    if (af_mode == 2) fetch_almost_full = ($urandom_range(0, 3) == 0);
    else if (stall_left > 0) begin fetch_almost_full = 1'b1; stall_left--; end
    else fetch_almost_full = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge hbm_clk);
    #1;
  endtask

  task automatic start_xfer(input logic [63:0] a, input logic [31:0] len);
    longint unsigned cl;
    cl = ((longint'(len) + 63) / 64) * 64;
    exp_addr = a;
    exp_clen = 32'(cl);
    n_words = int'(len / 32);
    words_pushed = 0; words_seen = 0; beats_acc = 0; cmds = 0; done_cnt = 0;
    first_cyc = -1; last_cyc = 0; done_cyc = 0; busy_cyc = 0; cmdv_cyc = 0;
    exp_q.delete();
    addr_x = a;
    data_length = len;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic finish_xfer(input logic [31:0] len, input bit chk_tp);
    int t;
    t = 0;
    while (done_cnt == 0 && t < 4000) begin tick(1); t++; end
    tick(3);
    chk("done_cnt", done_cnt, 1);
    chk("cmds", cmds, (len != 0) ? 1 : 0);
    chk("beats", beats_acc, exp_clen / 64);
    chk("words", words_seen, n_words);
    chk("q_empty", exp_q.size(), 0);
    if (n_words > 0) chk("done_lat", done_cyc - last_cyc, 1);
    if (chk_tp) chk("throughput", last_cyc - first_cyc, n_words - 1);
  endtask

  initial begin
    int t;
    logic [31:0] rl;
    // Reset state.
    tick(3);
    @(negedge hbm_clk);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_fetch_data", fetch_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    tick(1);
    hbm_areset = 1'b0;
    tick(3);

    // Basic 256-byte transfer, full throughput.
    start_xfer(64'h1000, 32'd256);
    finish_xfer(32'd256, 1'b1);

    // Odd word count: upper half of the last beat dropped.
    start_xfer(64'h2000, 32'd96);
    finish_xfer(32'd96, 1'b1);

    // Fetch stall mid-transfer.
    start_xfer(64'h3000, 32'd128);
    t = 0;
    while (words_seen < 1 && t < 200) begin tick(1); t++; end
    stall_left = 10;
    af_mode = 1;
    tick(4);
    chk("stall_s_ready", s_ready, 0);
    finish_xfer(32'd128, 1'b0);
    af_mode = 0;

    // Zero length.
    start_xfer(64'h4000, 32'd0);
    finish_xfer(32'd0, 1'b0);
    chk("len0_no_cmd", cmdv_cyc, 0);
    chk("len0_busy", (busy_cyc >= 1) && (busy_cyc <= 2), 1);

    // Command ready withheld; start re-pulsed mid-transfer.
    cmd_delay = 20;
    start_xfer(64'h5000_0000_0040, 32'd192);
    tick(5);
    addr_x = 64'hDEAD_BEEF_0000;
    data_length = 32'd1024;
    start = 1'b1;
    tick(3);
    start = 1'b0;
    finish_xfer(32'd192, 1'b1);
    chk("cmd_wait", cmdv_cyc, 21);
    cmd_delay = 0;

    // Reset after 2 of 4 beats.
    dma_mode = 1;
    start_xfer(64'h6000, 32'd256);
    t = 0;
    while (beats_acc < 2 && t < 500) begin tick(1); t++; end
    chk("rst_mid_beats", beats_acc, 2);
    hbm_areset = 1'b1;
    #1;
    chk("arst_fetch_valid", fetch_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cmd_valid", cmd_valid, 0);
    chk("arst_s_ready", s_ready, 0);
    chk("arst_done", done, 0);
    tick(3);
    hbm_areset = 1'b0;
    exp_q.delete();
    tick(6);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_idle", busy, 0);
    dma_mode = 0;
    start_xfer(64'h7000, 32'd256);
    finish_xfer(32'd256, 1'b1);

    // Randomized transfers.
    af_mode = 2;
    for (int k = 0; k < 8; k++) begin
      dma_mode = $urandom_range(0, 1);
      cmd_delay = $urandom_range(0, 3);
      rl = 32'($urandom_range(0, 20)) * 32'd32;
      start_xfer({$urandom, $urandom}, rl);
      finish_xfer(rl, 1'b0);
    end
    af_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
